// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin whole-frame arbiter for two octet requesters feeding the GMII transmit path,
// with exact inter-packet gap and forced termination of over-length frames.
module tx_frame_arbiter #(
  parameter int OCTET_WIDTH = 8,
  parameter int IPG_LEN     = 12,
  parameter int MAX_LEN     = 1522
) (
  input  logic                   gtx_clk,
  input  logic                   mr_main_reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [OCTET_WIDTH-1:0] data0,
  input  logic [OCTET_WIDTH-1:0] data1,
  input  logic                   last0,
  input  logic                   last1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   tx_en,
  output logic [OCTET_WIDTH-1:0] txd,
  output logic                   busy,
  output logic                   len_err
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(IPG_LEN + 1);
  typedef enum logic [1:0] {IDLE, TX, IPG} state_t;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [GW-1:0]          gap;
  logic                   last_served;
  logic                   any_req;
  logic                   pick;
  logic                   cur_last;
  logic                   at_max;
  logic [OCTET_WIDTH-1:0] cur_data;
  // gnt1 identifies the owner while in TX, so no separate select register is needed
  always_comb begin
    any_req  = req0 | req1;
    pick     = req1 & (~req0 | ~last_served);
    cur_data = gnt1 ? data1 : data0;
    cur_last = gnt1 ? last1 : last0;
    at_max   = cnt == CW'(MAX_LEN - 1);
  end
  always_ff @(posedge gtx_clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      gap         <= '0;
      last_served <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      tx_en       <= 1'b0;
      txd         <= '0;
      busy        <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      tx_en   <= state == TX;
      txd     <= state == TX ? cur_data : '0;
      len_err <= state == TX && at_max && !cur_last;
      if (state == TX) begin
        cnt <= cnt + 1'b1;
        if (cur_last || at_max) begin
          state <= IPG;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          gap   <= GW'(IPG_LEN - 1);
        end
      end else if (state == IPG && gap != '0) begin
        gap <= gap - 1'b1;
      end else if (any_req) begin
        state       <= TX;
        gnt0        <= ~pick;
        gnt1        <= pick;
        last_served <= pick;
        busy        <= 1'b1;
        cnt         <= '0;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: randomized and directed checks of two arbiter instances (IPG 12 / MAX 64 and IPG 1 / MAX 16)
// against a frame-level reference model.
module tb_tx_frame_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req [2][2];
  logic [7:0] data [2][2];
  logic       last [2][2];
  logic       gnt [2][2];
  logic       tx_en [2];
  logic [7:0] txd [2];
  logic       busy [2];
  logic       len_err [2];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int m_own [2], m_len [2], m_since [2];
  logic m_ls [2];
  logic [12:0] e_vec [2];
  int pend [2][2], flen [2][2], idx [2][2], hold [2][2];
  logic [7:0] base [2][2];
  logic nl [2][2], rnd [2][2];
  int run [2], gap_run [2], nb [2], ng [2], ngr [2], nlerr [2], lerr_at [2], tx_rise [2], gnt_rise [2];
  int bursts [2][16], gaps [2][16], grants [2][16], gcnt [2][2];
  logic seen [2];
  logic gprev [2][2];

  tx_frame_arbiter #(.OCTET_WIDTH(8), .IPG_LEN(12), .MAX_LEN(64)) dut0 (
    .gtx_clk(clk), .mr_main_reset(rst),
    .req0(req[0][0]), .req1(req[0][1]), .data0(data[0][0]), .data1(data[0][1]),
    .last0(last[0][0]), .last1(last[0][1]), .gnt0(gnt[0][0]), .gnt1(gnt[0][1]),
    .tx_en(tx_en[0]), .txd(txd[0]), .busy(busy[0]), .len_err(len_err[0])
  );
  tx_frame_arbiter #(.OCTET_WIDTH(8), .IPG_LEN(1), .MAX_LEN(16)) dut1 (
    .gtx_clk(clk), .mr_main_reset(rst),
    .req0(req[1][0]), .req1(req[1][1]), .data0(data[1][0]), .data1(data[1][1]),
    .last0(last[1][0]), .last1(last[1][1]), .gnt0(gnt[1][0]), .gnt1(gnt[1][1]),
    .tx_en(tx_en[1]), .txd(txd[1]), .busy(busy[1]), .len_err(len_err[1])
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic int ipg(int d);
    return d == 0 ? 12 : 1;
  endfunction
  function automatic int maxl(int d);
    return d == 0 ? 64 : 16;
  endfunction
  function automatic logic [12:0] act(int d);
    return {gnt[d][0], gnt[d][1], tx_en[d], busy[d], len_err[d], txd[d]};
  endfunction

  task automatic chk(string name, int a, int e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1;
      m_len[d] = 0;
      m_since[d] = ipg(d);
      m_ls[d] = 1'b1;
      e_vec[d] = '0;
    end
  endtask

  // Frame-level view: a port owns the line until its last octet or MAX_LEN octets,
  // then nobody may start until IPG_LEN edges have passed since that end.
  task automatic step_model(int d);
    logic et, el, eg0, eg1, eb;
    logic [7:0] ed;
    logic lt;
    et = 0; el = 0; ed = '0;
    if (m_own[d] >= 0) begin
      lt = last[d][m_own[d]];
      et = 1;
      ed = data[d][m_own[d]];
      m_len[d]++;
      el = m_len[d] == maxl(d) && !lt;
      if (lt || m_len[d] == maxl(d)) begin
        m_own[d] = -1;
        m_since[d] = 0;
      end
    end else begin
      if (m_since[d] < ipg(d)) m_since[d]++;
      if (m_since[d] >= ipg(d) && (req[d][0] || req[d][1])) begin
        m_own[d] = (req[d][0] && req[d][1]) ? (m_ls[d] ? 0 : 1) : (req[d][1] ? 1 : 0);
        m_ls[d] = m_own[d] == 1;
        m_len[d] = 0;
      end
    end
    eg0 = m_own[d] == 0;
    eg1 = m_own[d] == 1;
    eb = m_own[d] >= 0 || m_since[d] < ipg(d);
    e_vec[d] = {eg0, eg1, et, eb, el, ed};
  endtask

  task automatic new_frame(int d, int p);
    idx[d][p] = 0;
    flen[d][p] = $urandom_range(1, maxl(d) + 4);
    nl[d][p] = $urandom_range(0, 7) == 0;
    hold[d][p] = $urandom_range(0, 15);
    base[d][p] = 8'($urandom);
  endtask

  task automatic plan(int d, int p, int n, int len, logic [7:0] b, logic nolast, int h, logic r);
    pend[d][p] = n;
    flen[d][p] = len;
    base[d][p] = b;
    nl[d][p] = nolast;
    hold[d][p] = h;
    idx[d][p] = 0;
    rnd[d][p] = r;
    if (r) new_frame(d, p);
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        req[d][p] = pend[d][p] > 0 && hold[d][p] == 0;
        data[d][p] = base[d][p] + 8'(idx[d][p]);
        last[d][p] = pend[d][p] > 0 && !nl[d][p] && idx[d][p] == flen[d][p] - 1;
      end
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      run[d] = 0; gap_run[d] = 0; nb[d] = 0; ng[d] = 0; ngr[d] = 0; nlerr[d] = 0;
      lerr_at[d] = 0; tx_rise[d] = 0; gnt_rise[d] = 0; seen[d] = 0;
      for (int p = 0; p < 2; p++) begin
        gcnt[d][p] = 0;
        gprev[d][p] = gnt[d][p];
      end
    end
  endtask

  task automatic monitor(int d);
    if (tx_en[d]) begin
      if (run[d] == 0) begin
        if (seen[d] && ng[d] < 16) gaps[d][ng[d]] = gap_run[d];
        if (seen[d]) ng[d]++;
        tx_rise[d] = cyc;
      end
      run[d]++;
      gap_run[d] = 0;
    end else begin
      if (run[d] > 0) begin
        if (nb[d] < 16) bursts[d][nb[d]] = run[d];
        nb[d]++;
        seen[d] = 1;
      end
      run[d] = 0;
      gap_run[d]++;
    end
    if (len_err[d]) begin
      lerr_at[d] = run[d];
      nlerr[d]++;
    end
    for (int p = 0; p < 2; p++) begin
      if (gnt[d][p] && !gprev[d][p]) begin
        if (ngr[d] < 16) grants[d][ngr[d]] = p;
        ngr[d]++;
        gnt_rise[d] = cyc;
      end
      if (gnt[d][p]) gcnt[d][p]++;
      gprev[d][p] = gnt[d][p];
    end
  endtask

  task automatic cycle();
    logic gp [2][2];
    logic lp [2][2];
    for (int d = 0; d < 2; d++) begin
      if (!rst) step_model(d);
      for (int p = 0; p < 2; p++) begin
        gp[d][p] = gnt[d][p];
        lp[d][p] = last[d][p];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (act(d) !== e_vec[d]) begin
        mismatched++;
        $display("FAIL dut%0d outputs cyc %0d: got %h expected %h (gnt0,gnt1,tx_en,busy,len_err,txd)",
                 d, cyc, act(d), e_vec[d]);
      end
      monitor(d);
      for (int p = 0; p < 2; p++) begin
        if (gp[d][p] && (lp[d][p] || !gnt[d][p])) begin
          pend[d][p]--;
          idx[d][p] = 0;
          if (pend[d][p] > 0 && rnd[d][p]) new_frame(d, p);
        end else if (gp[d][p]) begin
          idx[d][p]++;
        end else if (pend[d][p] > 0 && hold[d][p] > 0) begin
          hold[d][p]--;
        end
      end
    end
    drive();
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while (n < bound && !(pend[0][0] == 0 && pend[0][1] == 0 && pend[1][0] == 0 && pend[1][1] == 0 &&
                          m_own[0] < 0 && m_since[0] >= ipg(0) && m_own[1] < 0 && m_since[1] >= ipg(1))) begin
      cycle();
      n++;
    end
    chk("idle_within_bound", int'(n < bound), 1);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) plan(d, p, 0, 1, 8'h00, 1'b0, 0, 1'b0);
    model_reset();
    drive();
    repeat (3) cycle();
    clear_stats();
    rst = 1'b0;
    cycle();

    // Reset in the middle of a frame, then port 1 gets the line with no gap
    plan(0, 0, 1, 20, 8'h40, 1'b0, 0, 1'b0);
    drive();
    n = 0;
    while (run[0] != 5 && n < 100) begin
      cycle();
      n++;
    end
    chk("reach_octet5", run[0], 5);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_dut0", int'(act(0)), 0);
    chk("async_reset_dut1", int'(act(1)), 0);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) plan(d, p, 0, 1, 8'h00, 1'b0, 0, 1'b0);
    model_reset();
    drive();
    cycle();
    clear_stats();
    rst = 1'b0;
    plan(0, 1, 1, 8, 8'h80, 1'b0, 0, 1'b0);
    drive();
    cycle();
    chk("gnt1_after_reset", int'(gnt[0][1]), 1);
    cycle();
    chk("tx_en_after_reset", int'(tx_en[0]), 1);
    chk("txd_first_octet", int'(txd[0]), 8'h80);
    wait_idle(200);

    // Contention: three 10-octet frames per port
    clear_stats();
    plan(0, 0, 3, 10, 8'h10, 1'b0, 0, 1'b0);
    plan(0, 1, 3, 10, 8'h20, 1'b0, 0, 1'b0);
    drive();
    wait_idle(500);
    chk("rr_grant_count", ngr[0], 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_grant_%0d", i), grants[0][i], i % 2);
    chk("rr_gap_count", ng[0], 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_gap_%0d", i), gaps[0][i], 12);

    // 64-octet frame ending exactly at MAX_LEN is a normal end
    clear_stats();
    plan(0, 0, 1, 64, 8'h00, 1'b0, 0, 1'b0);
    drive();
    wait_idle(300);
    chk("single_burst_len", bursts[0][0], 64);
    chk("single_gnt_cycles", gcnt[0][0], 64);
    chk("single_len_err", nlerr[0], 0);
    chk("single_gnt_to_tx", tx_rise[0] - gnt_rise[0], 1);

    // Forced termination on dut0, then a waiting port 0 frame after the gap
    clear_stats();
    plan(0, 1, 1, 70, 8'h55, 1'b1, 0, 1'b0);
    plan(0, 0, 1, 5, 8'hA0, 1'b0, 3, 1'b0);
    drive();
    wait_idle(400);
    chk("forced_burst_len", bursts[0][0], 64);
    chk("forced_gnt_cycles", gcnt[0][1], 64);
    chk("forced_len_err_octet", lerr_at[0], 64);
    chk("forced_len_err_count", nlerr[0], 1);
    chk("forced_gap", gaps[0][0], 12);
    chk("forced_next_burst", bursts[0][1], 5);
    chk("forced_grant_order", grants[0][0] * 10 + grants[0][1], 10);

    // dut1: one-cycle gap between held frames, late request from idle, forced at 16
    clear_stats();
    plan(1, 0, 3, 4, 8'h11, 1'b0, 0, 1'b0);
    drive();
    wait_idle(100);
    chk("ipg1_bursts", nb[1], 3);
    chk("ipg1_gap0", gaps[1][0], 1);
    chk("ipg1_gap1", gaps[1][1], 1);
    cycle();
    plan(1, 0, 1, 3, 8'h30, 1'b0, 0, 1'b0);
    drive();
    cycle();
    chk("late_gnt", int'(gnt[1][0]), 1);
    chk("late_no_tx_yet", int'(tx_en[1]), 0);
    cycle();
    chk("late_tx", int'(tx_en[1]), 1);
    wait_idle(100);
    clear_stats();
    plan(1, 1, 1, 20, 8'h70, 1'b1, 0, 1'b0);
    drive();
    wait_idle(100);
    chk("forced16_burst", bursts[1][0], 16);
    chk("forced16_len_err_octet", lerr_at[1], 16);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) plan(d, p, 10, 1, 8'h00, 1'b0, 0, 1'b1);
    drive();
    wait_idle(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Round-robin frame arbiter and GMII-side sequencer feeding the PCS transmit block (`transmit_wrapper`). It shares the single `tx_en`/`txd` transmit path between two octet-stream requesters. It grants one whole frame at a time, enforces a minimum inter-packet gap, and force-terminates frames that exceed a maximum length. Runs in the `gtx_clk` domain; its `tx_en`/`txd` outputs connect directly to the transmit wrapper inputs.

## Interface
- `OCTET_WIDTH`, 8, width of data octets
- `IPG_LEN`, 12, exact number of `tx_en`-low cycles between back-to-back frames (minimum 1)
- `MAX_LEN`, 1522, maximum octets per frame before forced termination (minimum 1)

Ports:
- `gtx_clk`  in  1  transmit clock; the only clock
- `mr_main_reset`  in  1  reset, asynchronous, active-high
- `req0`, `req1`  in  1 each  requester N has a frame ready
- `data0`, `data1`  in  OCTET_WIDTH each  requester N current octet, sampled while `gntN`=1
- `last0`, `last1`  in  1 each  marks the final octet of the frame, sampled while `gntN`=1
- `gnt0`, `gnt1`  out  1 each  requester N owns the path; its octet is consumed every cycle this is high
- `tx_en`  out  1  to transmit wrapper
- `txd`  out  OCTET_WIDTH  to transmit wrapper
- `busy`  out  1  high in TX or IPG state
- `len_err`  out  1  one-cycle pulse on forced termination

## Operation
- States: IDLE, TX, IPG. All outputs are registered.
- Reset (async, immediate, including mid-frame):
  - State goes to IDLE.
  - `gnt0`=`gnt1`=`tx_en`=`busy`=`len_err`=0 and `txd`=0.
  - Octet counter is cleared. No IPG is enforced after reset.
  - `last_served`=1, so port 0 wins the first contention.
- Arbitration runs only in IDLE, or on the final IPG cycle:
  - One request pending: grant it.
  - Both pending: grant the port ≠ `last_served`, then set `last_served` to the granted port.
- IDLE → TX when any `reqN`=1. The selected `gntN` rises at that edge.
- TX:
  - Each cycle, `dataN`/`lastN` of the granted port are sampled.
  - At the edge, `tx_en`←1, `txd`←`dataN`, and the octet counter increments.
  - `reqN` is ignored during TX. The non-granted port's data is ignored.
  - Leave TX when sampled `lastN`=1, or when the counter reaches `MAX_LEN` with `lastN`=0 (forced termination). At that edge `gntN`←0 and state←IPG.
- Forced termination:
  - `len_err`=1 for one cycle, coincident with the final `tx_en`-high octet.
  - If `lastN`=1 on octet `MAX_LEN`, it is a normal end with no `len_err`.
  - The requester must treat the falling `gntN` as abort.
- IPG:
  - The gap counter loads `IPG_LEN`-1 on TX exit.
  - It decrements each cycle and occupies exactly `IPG_LEN` cycles.
  - `tx_en`=0 and `txd`=0 throughout IPG.
  - On the cycle the counter is 0: go to TX (with arbitration) if any `reqN`=1, else IDLE.
- Counter widths: octet counter `$clog2(MAX_LEN+1)`; gap counter `$clog2(IPG_LEN+1)`. Neither counter wraps.
- At most one `gntN` is high at any time. `gntN`=0 outside TX.

## Timing
- Request-to-grant: `reqN` high in IDLE at edge E → `gntN`=1 after E.
- Grant-to-data: the first octet must be valid in the first cycle `gntN` is high.
  - `tx_en`/`txd` lag `gntN` by exactly one cycle.
  - An N-octet frame gives `gntN` high for N cycles and `tx_en` high for N cycles.
- End of frame: `last` sampled at E0 → `gntN`=0 after E0. `tx_en` falls after E0+1.
- Back-to-back frames (request held): `tx_en` is low for exactly `IPG_LEN` cycles between frames. The next `gnt` rises `IPG_LEN` edges after E0.
- Request arriving in IDLE: grant 1 cycle later, first `tx_en` 2 cycles later.
- `busy` rises with `gnt` and falls on the IDLE transition.

## Test plan
- **Reset mid-frame.** Assert `mr_main_reset` while `tx_en`=1 on octet 5 → all outputs 0 immediately. After release, `req1` is granted with no IPG delay.
- **Single frame.** `req0` with 64 octets 0x00..0x3F → `gnt0` high 64 cycles. `tx_en` high 64 cycles starting 1 cycle after `gnt0`; `txd` sequence matches the input; `len_err`=0.
- **Contention and round-robin.** `req0`,`req1` rise in the same cycle, each holding three 10-octet frames → grants alternate 0,1,0,1,0,1. Each gap has exactly 12 `tx_en`-low cycles.
- **Forced termination.** Set `MAX_LEN`=16 and send a 20-octet frame on port 1 with `last1` never asserted → `tx_en` high 16 cycles. `len_err` pulses with octet 16. `gnt1` drops after 16 cycles, followed by 12 gap cycles.
- **Length boundary.** `last0` on exactly octet `MAX_LEN` → normal end, `len_err`=0.
- **Late request and gap minimum.** Set `IPG_LEN`=1; hold `req0` continuously → exactly one `tx_en`-low cycle between frames. A request arriving after IPG has expired is granted from IDLE one cycle later.
